// File: rtl/sprite_compositor_if.sv
// Pixel/colour bus between the address-generation side and the sprite compositor.
// The master drives pixel inputs; the slave (compositor) drives registered video outputs.
interface sprite_compositor_if #(
   parameter int unsigned NUM_LAYERS  = 8,
   parameter int unsigned COLOR_W     = 24,
   parameter int unsigned ANIM_FRAMES = 4
);
   localparam int unsigned HitW = $clog2(NUM_LAYERS) + 1;
   localparam int unsigned AfW  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

   logic                          pix_valid;
   logic [9:0]                    DrawX;
   logic [9:0]                    DrawY;
   logic [NUM_LAYERS-1:0]         layer_hit;
   logic [NUM_LAYERS*COLOR_W-1:0] layer_color;
   logic [COLOR_W-1:0]            bg_color;
   logic [1:0]                    mode;
   logic                          frame_start;
   logic                          anim_en;

   logic [AfW-1:0]                anim_frame;
   logic                          out_valid;
   logic [7:0]                    VGA_R;
   logic [7:0]                    VGA_G;
   logic [7:0]                    VGA_B;
   logic [9:0]                    out_x;
   logic [9:0]                    out_y;
   logic [HitW-1:0]               hit_layer;

   modport master (
      output pix_valid, DrawX, DrawY, layer_hit, layer_color, bg_color, mode,
      output frame_start, anim_en,
      input  anim_frame, out_valid, VGA_R, VGA_G, VGA_B, out_x, out_y, hit_layer
   );

   modport slave (
      input  pix_valid, DrawX, DrawY, layer_hit, layer_color, bg_color, mode,
      input  frame_start, anim_en,
      output anim_frame, out_valid, VGA_R, VGA_G, VGA_B, out_x, out_y, hit_layer
   );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage priority compositor of NUM_LAYERS colour-keyed sprite layers over a background,
// plus the global animation-frame counter. All outputs are registered.
module sprite_compositor #(
   parameter int unsigned         NUM_LAYERS  = 8,
   parameter int unsigned         COLOR_W     = 24,
   parameter logic [COLOR_W-1:0]  KEY_COLOR   = 24'hFFFFFF,
   parameter int unsigned         ANIM_FRAMES = 4,
   parameter int unsigned         ANIM_DIV    = 8
) (
   input  logic                Clk,
   input  logic                Reset,
   sprite_compositor_if.slave  bus
);
   localparam int unsigned HitW = $clog2(NUM_LAYERS) + 1;
   localparam int unsigned AfW  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   localparam int unsigned DivW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
   localparam int unsigned LcW  = NUM_LAYERS * COLOR_W;

   // Stage 1 registers
   logic                  v1_q;
   logic [9:0]            x1_q, y1_q;
   logic [1:0]            mode1_q;
   logic [COLOR_W-1:0]    bg1_q;
   logic [NUM_LAYERS-1:0] opaque1_q, opaque_d;
   logic [LcW-1:0]        col1_q;

   // Output registers
   logic                  v2_q;
   logic [9:0]            x2_q, y2_q;
   logic [COLOR_W-1:0]    rgb_q, rgb_d;
   logic [HitW-1:0]       hit_q, hit_d;

   // Animation state
   logic [DivW-1:0]       div_q, div_d;
   logic [AfW-1:0]        af_q, af_d;

   always_comb begin
      opaque_d = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         opaque_d[i] = bus.layer_hit[i] &&
                       (bus.layer_color[i*COLOR_W +: COLOR_W] != KEY_COLOR);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         v1_q      <= 1'b0;
         x1_q      <= '0;
         y1_q      <= '0;
         mode1_q   <= '0;
         bg1_q     <= '0;
         opaque1_q <= '0;
         col1_q    <= '0;
      end else begin
         v1_q      <= bus.pix_valid;
         x1_q      <= bus.DrawX;
         y1_q      <= bus.DrawY;
         mode1_q   <= bus.mode;
         bg1_q     <= bus.bg_color;
         opaque1_q <= opaque_d;
         col1_q    <= bus.layer_color;
      end
   end

   // Scan from the lowest priority upward so the lowest opaque index is written last.
   always_comb begin
      rgb_d = bg1_q;
      hit_d = '1;
      unique case (mode1_q)
         2'd0: begin
            for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
               if (opaque1_q[i]) begin
                  rgb_d = col1_q[i*COLOR_W +: COLOR_W];
                  hit_d = HitW'(i);
               end
            end
         end
         2'd1: rgb_d = 24'h880088;
         2'd2: rgb_d = {8'h7B, 8'hFF, 8'h7F - {1'b0, x1_q[9:3]}};
         2'd3: rgb_d = '0;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         v2_q  <= 1'b0;
         x2_q  <= '0;
         y2_q  <= '0;
         rgb_q <= '0;
         hit_q <= '1;
      end else begin
         v2_q  <= v1_q;
         x2_q  <= x1_q;
         y2_q  <= y1_q;
         rgb_q <= rgb_d;
         hit_q <= hit_d;
      end
   end

   always_comb begin
      div_d = div_q;
      af_d  = af_q;
      if (bus.frame_start && bus.anim_en) begin
         if (div_q == DivW'(ANIM_DIV - 1)) begin
            div_d = '0;
            af_d  = (af_q == AfW'(ANIM_FRAMES - 1)) ? '0 : af_q + 1'b1;
         end else begin
            div_d = div_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_q <= '0;
         af_q  <= '0;
      end else begin
         div_q <= div_d;
         af_q  <= af_d;
      end
   end

   assign bus.out_valid  = v2_q;
   assign bus.out_x      = x2_q;
   assign bus.out_y      = y2_q;
   assign bus.VGA_R      = rgb_q[16 +: 8];
   assign bus.VGA_G      = rgb_q[8 +: 8];
   assign bus.VGA_B      = rgb_q[0 +: 8];
   assign bus.hit_layer  = hit_q;
   assign bus.anim_frame = af_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: stimulus pushes expected pixels into a scoreboard
// tagged with the cycle they are due; a negedge monitor pops and compares them.
module tb_sprite_compositor;
   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   sprite_compositor_if #(.NUM_LAYERS(8), .COLOR_W(24), .ANIM_FRAMES(4)) bus ();

   sprite_compositor #(
      .NUM_LAYERS (8),
      .COLOR_W    (24),
      .KEY_COLOR  (24'hFFFFFF),
      .ANIM_FRAMES(4),
      .ANIM_DIV   (8)
   ) dut (
      .Clk  (Clk),
      .Reset(Reset),
      .bus  (bus)
   );

   typedef struct {
      int          due;
      bit          v;
      logic [23:0] rgb;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [3:0]  hit;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           n_vec = 0;
   int           n_err = 0;
   logic [191:0] lcol;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   // Monitor: runs on the negedge, before the stimulus that follows it by #1.
   always @(negedge Clk) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
         chk("missed_output", 32'(sb[0].due), 32'(cyc));
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, e.v});
         if (e.v) begin
            chk("rgb", {8'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'd0, e.rgb});
            chk("out_x", {22'd0, bus.out_x}, {22'd0, e.x});
            chk("out_y", {22'd0, bus.out_y}, {22'd0, e.y});
            chk("hit_layer", {28'd0, bus.hit_layer}, {28'd0, e.hit});
         end
      end else if (bus.out_valid === 1'b1) begin
         chk("unexpected_valid", {31'd0, bus.out_valid}, 32'd0);
      end
   end

   // Drive one cycle of inputs, record the expectation, then advance to the next negedge+1.
   task automatic step(input bit rst, input bit pv, input logic [9:0] x, input logic [9:0] y,
                       input logic [1:0] md, input logic [7:0] hits, input logic [23:0] bg,
                       input bit fs, input bit ae, input logic [23:0] ergb,
                       input logic [3:0] ehit);
      exp_t e;
      Reset           = rst;
      bus.pix_valid   = pv;
      bus.DrawX       = x;
      bus.DrawY       = y;
      bus.mode        = md;
      bus.layer_hit   = hits;
      bus.layer_color = lcol;
      bus.bg_color    = bg;
      bus.frame_start = fs;
      bus.anim_en     = ae;
      if (rst) begin
         sb.delete();
         e = '{due: cyc + 1, v: 1'b0, rgb: '0, x: '0, y: '0, hit: '0};
         sb.push_back(e);
         e.due = cyc + 2;
         sb.push_back(e);
      end else begin
         e = '{due: cyc + 2, v: pv, rgb: ergb, x: x, y: y, hit: ehit};
         sb.push_back(e);
      end
      @(negedge Clk);
      #1;
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [1:0] md,
                      input logic [7:0] hits, input logic [23:0] bg,
                      input logic [23:0] ergb, input logic [3:0] ehit);
      step(1'b0, 1'b1, x, y, md, hits, bg, 1'b0, 1'b0, ergb, ehit);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic pulse(input int n, input bit ae);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b1, ae, '0, '0);
   endtask

   initial begin
      lcol = '0;
      @(negedge Clk);
      #1;
      step(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_rgb", {8'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
      chk("rst_xy", {12'd0, bus.out_x, bus.out_y}, 32'd0);
      chk("rst_hit", {28'd0, bus.hit_layer}, 32'h0000000F);
      chk("rst_anim", {30'd0, bus.anim_frame}, 32'd0);

      // Background only
      pix(10'd5, 10'd7, 2'd0, 8'h00, 24'h123456, 24'h123456, 4'hF);
      // Keyed layer 1 falls through to layer 2, then becomes opaque
      lcol[1*24 +: 24] = 24'hFFFFFF;
      lcol[2*24 +: 24] = 24'h00FF00;
      pix(10'd10, 10'd1, 2'd0, 8'b0000_0110, 24'hABCDEF, 24'h00FF00, 4'h2);
      lcol[1*24 +: 24] = 24'hFF0000;
      pix(10'd11, 10'd1, 2'd0, 8'b0000_0110, 24'hABCDEF, 24'hFF0000, 4'h1);
      // Lowest layer alone; keyed layer 0 over a key-coloured background
      lcol[7*24 +: 24] = 24'h0A0B0C;
      lcol[0*24 +: 24] = 24'hFFFFFF;
      pix(10'd12, 10'd2, 2'd0, 8'b1000_0000, 24'h000001, 24'h0A0B0C, 4'h7);
      pix(10'd13, 10'd2, 2'd0, 8'b0000_0001, 24'hFFFFFF, 24'hFFFFFF, 4'hF);
      lcol[0*24 +: 24] = 24'h010203;
      pix(10'd14, 10'd2, 2'd0, 8'b1000_0111, 24'h000000, 24'h010203, 4'h0);

      // Test modes, changing every pixel
      pix(10'd80, 10'd3, 2'd2, 8'hFF, 24'h555555, 24'h7BFF75, 4'hF);
      pix(10'd1023, 10'd3, 2'd2, 8'h00, 24'h555555, 24'h7BFF00, 4'hF);
      pix(10'd81, 10'd3, 2'd1, 8'hFF, 24'h555555, 24'h880088, 4'hF);
      pix(10'd82, 10'd3, 2'd3, 8'hFF, 24'h555555, 24'h000000, 4'hF);
      pix(10'd83, 10'd3, 2'd0, 8'h00, 24'h555555, 24'h555555, 4'hF);

      // Bubbles: pix_valid 1,0,1,1
      pix(10'd20, 10'd9, 2'd0, 8'h00, 24'h202020, 24'h202020, 4'hF);
      idle(1);
      pix(10'd22, 10'd9, 2'd0, 8'h00, 24'h222222, 24'h222222, 4'hF);
      pix(10'd23, 10'd9, 2'd0, 8'h00, 24'h232323, 24'h232323, 4'hF);
      idle(3);

      // Animation counter
      pulse(8, 1'b1);
      chk("anim_8", {30'd0, bus.anim_frame}, 32'd1);
      pulse(23, 1'b1);
      chk("anim_31", {30'd0, bus.anim_frame}, 32'd3);
      pulse(1, 1'b1);
      chk("anim_32", {30'd0, bus.anim_frame}, 32'd0);
      pulse(5, 1'b1);
      pulse(20, 1'b0);
      chk("anim_hold", {30'd0, bus.anim_frame}, 32'd0);
      pulse(3, 1'b1);
      chk("anim_resume", {30'd0, bus.anim_frame}, 32'd1);

      // Reset together with frame_start while pixels are in flight
      pix(10'd30, 10'd4, 2'd0, 8'h00, 24'h303030, 24'h303030, 4'hF);
      pix(10'd31, 10'd4, 2'd0, 8'h00, 24'h313131, 24'h313131, 4'hF);
      step(1'b1, 1'b1, 10'd99, 10'd4, 2'd0, 8'h00, 24'h999999, 1'b1, 1'b1, '0, '0);
      chk("rst_fs_anim", {30'd0, bus.anim_frame}, 32'd0);
      pix(10'd32, 10'd4, 2'd0, 8'h00, 24'h323232, 24'h323232, 4'hF);
      pix(10'd33, 10'd4, 2'd0, 8'h00, 24'h333333, 24'h333333, 4'hF);
      pulse(7, 1'b1);
      chk("rst_div_7", {30'd0, bus.anim_frame}, 32'd0);
      pulse(1, 1'b1);
      chk("rst_div_8", {30'd0, bus.anim_frame}, 32'd1);

      idle(4);
      repeat (3) @(negedge Clk);
      #1;
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised, pipelined successor to the single-screen colour mapper.
- Merges NUM_LAYERS sprite/tile colour streams over a background by fixed priority, with colour-key transparency and selectable test/display modes.
- Owns the global animation-frame counter used by sprite address generators to select frame ROMs.
- Sits between the ROM/address-generation logic and the VGA output pins; all outputs are registered.

Parameters:
- NUM_LAYERS, 8, number of sprite layers; layer 0 is highest priority.
- COLOR_W, 24, packed RGB width (8 bits per channel).
- KEY_COLOR, 24'hFFFFFF, transparent colour key.
- ANIM_FRAMES, 4, number of animation frames; anim_frame wraps modulo this value.
- ANIM_DIV, 8, number of video frames per animation step (ANIM_DIV must be at least 1).

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  reset.
- pix_valid  in  1  pixel inputs are valid this cycle.
- DrawX  in  10  current pixel X.
- DrawY  in  10  current pixel Y.
- layer_hit  in  NUM_LAYERS  per-layer "pixel inside sprite box".
- layer_color  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i occupies bits [i*COLOR_W +: COLOR_W].
- bg_color  in  COLOR_W  background/map colour for this pixel.
- mode  in  2  display mode: 0 composite, 1 solid test, 2 gradient, 3 blank.
- frame_start  in  1  one-cycle pulse at the start of each video frame.
- anim_en  in  1  enables animation advance.
- anim_frame  out  clog2(ANIM_FRAMES) (minimum 1)  current animation frame.
- out_valid  out  1  pixel outputs are valid.
- VGA_R, VGA_G, VGA_B  out  8 each  output colour.
- out_x, out_y  out  10 each  coordinates aligned with the output colour.
- hit_layer  out  clog2(NUM_LAYERS)+1  index of the winning layer; all-ones when the background is shown.

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values:
  - out_valid=0.
  - VGA_R/G/B=0.
  - out_x=out_y=0.
  - hit_layer=all-ones.
  - anim_frame=0; internal divider=0.
  - All pipeline valid bits=0.
- Pipeline timing:
  - 2-stage pipeline with no stall; both stages advance every cycle.
  - Latency is exactly 2 cycles: inputs sampled at edge N appear on the outputs after edge N+1.
  - out_valid is pix_valid delayed by 2 cycles.
  - When out_valid=0, the colour, coordinate and hit_layer outputs are don't-care.
  - A bubble (pix_valid=0) propagates as out_valid=0.
- Stage 1 registers:
  - DrawX, DrawY, mode, bg_color.
  - Per-layer opaque mask: opaque[i] = layer_hit[i] AND (layer colour != KEY_COLOR).
  - All layer colours.
- Stage 2 compositing, by mode:
  - Mode 0: the lowest-index opaque layer wins; its colour is output and hit_layer = that index. If no layer is opaque, output bg_color and hit_layer = all-ones. A bg_color equal to KEY_COLOR is still displayed (no key on the background).
  - Mode 1: output 88_00_88; hit_layer = all-ones.
  - Mode 2: R=7B, G=FF, B = 7F − {1'b0, X[9:3]}, computed in 8-bit modulo arithmetic from the stage-1 X value; hit_layer = all-ones.
  - Mode 3: output 000000; hit_layer = all-ones.
- Mode is sampled per pixel; a change mid-line takes effect on the pixel sampled with the new value.
- Animation counter:
  - On a cycle with frame_start=1 and anim_en=1: if divider == ANIM_DIV−1, divider←0 and anim_frame←(anim_frame+1) mod ANIM_FRAMES; otherwise divider←divider+1.
  - anim_en=0: divider and anim_frame hold.
  - frame_start without anim_en has no effect.
  - anim_frame is registered and changes only on the cycle after a qualifying frame_start.
- Simultaneous Reset and frame_start: reset wins; counters are 0 afterwards.
- Reset mid-line: in-flight pixels are discarded; out_valid is 0 for the first 2 cycles after release, even if pix_valid=1.

Test Plan:
- Reset, then pix_valid=1, mode=0, layer_hit=0, bg_color=123456, X=5, Y=7 → two cycles later: out_valid=1, RGB=12/34/56, out_x=5, out_y=7, hit_layer=all-ones.
- Priority and key: layer_hit=0b00000110, layer1 colour = FFFFFF, layer2 colour = 00FF00 → output 00FF00, hit_layer=2. Then set layer1 colour = FF0000 → output FF0000, hit_layer=1.
- Gradient and test modes:
  - mode=2, X=80 → RGB=7B/FF/75.
  - mode=2, X=1023 → B = 7F−7F = 00.
  - mode=1 → 88/00/88.
  - mode=3 → 00/00/00.
- Animation (ANIM_DIV=8, ANIM_FRAMES=4), anim_en=1:
  - 8 frame_start pulses → anim_frame=1.
  - 32 pulses → wraps to 0.
  - 31 pulses → anim_frame=3.
  - Pulses with anim_en=0 leave anim_frame unchanged.
- Pipeline bubbles: pix_valid pattern 1,0,1,1 → out_valid 1,0,1,1 delayed exactly 2 cycles, with coordinates matching per pixel.
- Reset asserted in the same cycle as frame_start, while pixels are in flight → anim_frame=0, and out_valid=0 for 2 cycles after release.
